// File: rtl/ifetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: opcodes, fetch FSM
// states and the default reset vector.
package ifetch_stage_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_VALID = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/ifetch_stage_npc_calc.sv
// Next-PC selection for the held instruction: jump beats taken branch,
// otherwise fall through to pc_plus4.
module npc_calc
   import ifetch_stage_pkg::*;
(
   input  logic [31:0] pc_plus4,
   input  logic [31:0] instr,
   input  logic        jump,
   input  logic        branch,
   input  logic        zero,
   output logic [31:0] next_pc
);

   logic [31:0] jump_target;
   logic [31:0] branch_target;
   logic        unused_opcode;

   assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
   assign branch_target = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
   assign unused_opcode = ^instr[31:26];

   always_comb begin
      next_pc = pc_plus4;
      if (jump)
         next_pc = jump_target;
      else if (branch && zero)
         next_pc = branch_target;
   end

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: requests one word at pc, holds it until the
// downstream consumes it, then advances pc through npc_calc.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | one cycle after reset release, no request
// ST_FETCH | imem_req high at imem_addr=pc, waiting for imem_ready
// ST_VALID | instr held with instr_valid high, waiting for stall=0
module ifetch_stage
   import ifetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        jump,
   input  logic        branch,
   input  logic        zero,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic        instr_valid,
   output logic [31:0] pc_plus4
);

   localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  next_pc;

   assign imem_addr = pc;
   assign pc_plus4  = pc + 32'd4;
   assign opcode    = instr[31:26];

   npc_calc u_npc_calc (
      .pc_plus4 (pc_plus4),
      .instr    (instr),
      .jump     (jump),
      .branch   (branch),
      .zero     (zero),
      .next_pc  (next_pc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         pc          <= START_PC;
         instr       <= 32'd0;
         instr_valid <= 1'b0;
         imem_req    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               state    <= ST_FETCH;
               imem_req <= 1'b1;
            end
            ST_FETCH: begin
               if (imem_ready) begin
                  instr       <= imem_rdata;
                  instr_valid <= 1'b1;
                  imem_req    <= 1'b0;
                  state       <= ST_VALID;
               end
            end
            ST_VALID: begin
               // jump/branch/zero only matter in the consuming cycle
               if (!stall) begin
                  pc          <= {next_pc[31:2], 2'b00};
                  instr_valid <= 1'b0;
                  imem_req    <= 1'b1;
                  state       <= ST_FETCH;
               end
            end
            default: begin
               state    <= ST_IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/ifetch_stage.md
IFETCH_STAGE -- requirements
Module: ifetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset; bits [1:0] are forced to 0.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 stall  input  1  downstream not ready to consume the held instruction.
REQ-005 jump  input  1  decoder Jump for the held instruction.
REQ-006 branch  input  1  decoder Branch for the held instruction.
REQ-007 zero  input  1  ALU zero flag for the held instruction.
REQ-008 imem_req  output  1  instruction memory read request.
REQ-009 imem_addr  output  32  byte address of the request (equals pc).
REQ-010 imem_ready  input  1  read data valid this cycle.
REQ-011 imem_rdata  input  32  instruction word.
REQ-012 instr  output  32  held instruction word.
REQ-013 opcode  output  6  instr[31:26], feeds the main control decoder.
REQ-014 instr_valid  output  1  instr holds a fetched, unconsumed instruction.
REQ-015 pc_plus4  output  32  pc + 4 of the held instruction.

Function
REQ-016 FSM states SHALL be IDLE, FETCH and VALID.
REQ-017 IDLE SHALL last exactly one cycle after rst deasserts, then go to FETCH.
REQ-018 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc, held stable until imem_ready=1.
REQ-019 In FETCH with imem_ready=1: instr<=imem_rdata, instr_valid<=1, state->VALID; minimum request-to-valid latency is 1 cycle.
REQ-020 imem_ready while imem_req=0 SHALL be ignored.
REQ-021 In VALID, imem_req SHALL be 0, and instr and instr_valid SHALL hold while stall=1.
REQ-022 An instruction is consumed in a VALID cycle with stall=0: pc<=next_pc, instr_valid<=0, state->FETCH.
REQ-023 next_pc SHALL be {pc_plus4[31:28], instr[25:0], 2'b00} if jump=1.
REQ-024 Otherwise next_pc SHALL be pc_plus4 + (sign-extended instr[15:0] << 2) if branch=1 and zero=1.
REQ-025 Otherwise next_pc SHALL be pc_plus4.
REQ-026 Jump SHALL take priority when jump and branch are both 1.
REQ-027 jump, branch and zero SHALL be sampled only in the consuming cycle; they are don't-care elsewhere.
REQ-028 PC arithmetic SHALL be modulo 2^32: pc 32'hFFFF_FFFC gives pc_plus4 32'h0000_0000.
REQ-029 pc[1:0] SHALL always be 2'b00.

Reset
REQ-030 On rst=1 at a clock edge: pc=RESET_PC, state=IDLE, instr=0, instr_valid=0, imem_req=0.
REQ-031 Reset during an outstanding FETCH SHALL abandon the request; a late imem_ready SHALL NOT load instr.
REQ-032 Reset SHALL take priority over every simultaneous event.

Structure
REQ-033 A shared package SHALL hold the opcode constants (R-type 000000, J 000010, BEQ 000100, ADDI 001000, LW 100011, SW 101011), the FSM state enum and the RESET_PC default.
REQ-034 Next-PC selection SHALL be a combinational sub-module npc_calc (inputs pc_plus4, instr, jump, branch, zero; output next_pc).

Verification
REQ-035 Reset release with imem_ready tied 1 and rdata 32'h2008_0005 -> imem_addr 0 asserted; instr_valid=1 and opcode=6'b001000 one cycle after the request.
REQ-036 imem_ready delayed 3 cycles -> imem_req and imem_addr held constant for 4 cycles, then instr_valid=1.
REQ-037 Held BEQ 32'h1000_FFFF at pc 0x40 with branch=1, zero=1, stall=0 -> next imem_addr 0x40; with zero=0 -> 0x44.
REQ-038 Held J 32'h0800_0010 at pc 0x1000_0000 with jump=1 and branch=1 -> next imem_addr 0x1000_0040.
REQ-039 stall=1 for 5 cycles in VALID -> instr stable, imem_req=0; stall=0 -> fetch of pc_plus4.
REQ-040 rst pulsed during FETCH with imem_ready arriving the next cycle -> instr_valid stays 0 and imem_addr restarts at RESET_PC.
